// File: rtl/int_sqrt_sched_pkg.sv
// rtl/int_sqrt_sched_pkg.sv - shared types and helpers for the sqrt scheduler
package int_sqrt_sched_pkg;

  // Sequencer states for the shared square-root unit
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  // Width of a channel index; at least one bit even for degenerate N
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_sqrt_sched_rr_pick.sv
// rtl/int_sqrt_sched_rr_pick.sv - combinational round-robin picker
module int_sqrt_sched_rr_pick
  import int_sqrt_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  pend,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk ptr+1 .. ptr+N (mod N) and keep the first pending channel
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < N; k++) begin
      idx = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
      if (!found && pend[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/int_sqrt_sched.sv
// rtl/int_sqrt_sched.sv - time-shares one iterative sqrt unit among N requesters
module int_sqrt_sched
  import int_sqrt_sched_pkg::*;
#(
  parameter int N        = 4,
  parameter int IW       = 32,
  parameter int OW       = 16,
  parameter int SQRT_LAT = 17,
  parameter int CW       = 5
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [N-1:0]    iReq,
  input  logic [N*IW-1:0] iRadicand,
  output logic [N-1:0]    oValid,
  output logic [N*OW-1:0] oRoot,
  output logic            oBusy,
  output logic [IW-1:0]   oSqrtIn,
  output logic            oSqrtStart,
  input  logic [OW-1:0]   iSqrtOut
);

  localparam int PW = ptr_width(N);

  state_e                 state_q, state_d;
  logic [N-1:0]           pend_q, pend_d;
  logic [N-1:0][IW-1:0]   lat_q, lat_d;
  logic [PW-1:0]          rr_q, rr_d;
  logic [PW-1:0]          sel_q, sel_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          sqrt_in_q, sqrt_in_d;
  logic [N-1:0][OW-1:0]   root_q, root_d;
  logic [N-1:0]           valid_q, valid_d;

  logic [PW-1:0]          grant;
  logic                   any;

  int_sqrt_sched_rr_pick #(.N(N), .PW(PW)) u_pick (
    .pend  (pend_q),
    .ptr   (rr_q),
    .grant (grant),
    .any   (any)
  );

  // Next-state: grant, start/run/capture sequencing, then request latching (set beats grant clear)
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    lat_d      = lat_q;
    rr_d       = rr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    sqrt_in_d  = sqrt_in_q;
    root_d     = root_q;
    valid_d    = '0;
    oSqrtStart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          sel_d         = grant;
          sqrt_in_d     = lat_q[grant];
          pend_d[grant] = 1'b0;
          rr_d          = grant;
          state_d       = ST_LOAD;
        end
      end
      ST_LOAD: begin
        oSqrtStart = 1'b1;
        cnt_d      = CW'(SQRT_LAT - 1);
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CAPTURE: begin
        root_d[sel_q]  = iSqrtOut;
        valid_d[sel_q] = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    for (int i = 0; i < N; i++) begin
      if (iReq[i]) begin
        pend_d[i] = 1'b1;
        lat_d[i]  = iRadicand[i*IW +: IW];
      end
    end
  end

  // State and datapath registers; reset abandons any job in flight
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      lat_q     <= '0;
      rr_q      <= PW'(N - 1);
      sel_q     <= '0;
      cnt_q     <= '0;
      sqrt_in_q <= '0;
      root_q    <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      lat_q     <= lat_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      sqrt_in_q <= sqrt_in_d;
      root_q    <= root_d;
      valid_q   <= valid_d;
    end
  end

  assign oValid  = valid_q;
  assign oRoot   = root_q;
  assign oBusy   = (state_q != ST_IDLE);
  assign oSqrtIn = sqrt_in_q;

endmodule

// File: tb/tb_int_sqrt_sched.sv
// tb/tb_int_sqrt_sched.sv - self-checking bench for int_sqrt_sched
module tb_int_sqrt_sched;

  localparam int N        = 4;
  localparam int IW       = 32;
  localparam int OW       = 16;
  localparam int SQRT_LAT = 17;
  localparam int CW       = 5;
  localparam int JOB      = SQRT_LAT + 3;

  logic            iCLK;
  logic            iRST;
  logic [N-1:0]    iReq;
  logic [N*IW-1:0] iRadicand;
  logic [N-1:0]    oValid;
  logic [N*OW-1:0] oRoot;
  logic            oBusy;
  logic [IW-1:0]   oSqrtIn;
  logic            oSqrtStart;
  logic [OW-1:0]   iSqrtOut;

  int_sqrt_sched #(.N(N), .IW(IW), .OW(OW), .SQRT_LAT(SQRT_LAT), .CW(CW)) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iReq       (iReq),
    .iRadicand  (iRadicand),
    .oValid     (oValid),
    .oRoot      (oRoot),
    .oBusy      (oBusy),
    .oSqrtIn    (oSqrtIn),
    .oSqrtStart (oSqrtStart),
    .iSqrtOut   (iSqrtOut)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    int          ch;
    logic [31:0] rad;
  } job_t;

  job_t exp_q[$];
  job_t start_q[$];
  int   obs_ch[$];
  int   obs_root[$];
  int   obs_cyc[$];
  int   start_cyc[$];

  logic [N-1:0] m_pend;
  logic [31:0]  m_lat[N];
  logic [15:0]  m_root[N];
  int           m_rr = N - 1;
  int           m_free = 0;
  int           m_busy_from = 0;
  int           m_jobs = 0;

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint v;
    longint r;
    v = longint'(x);
    r = longint'($floor($sqrt(real'(v))));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return 16'(r);
  endfunction

  function automatic logic [31:0] rand_rad();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [N*IW-1:0] one_rad(input int ch, input logic [31:0] v);
    logic [N*IW-1:0] t;
    for (int i = 0; i < N; i++) t[i*IW +: IW] = $urandom;
    t[ch*IW +: IW] = v;
    return t;
  endfunction

  // Behavioural sqrt unit: garbage until SQRT_LAT cycles after start, then floor(sqrt)
  int          sq_cd;
  logic [15:0] sq_tgt;
  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sq_cd    <= 0;
      iSqrtOut <= 16'($urandom);
    end else if (oSqrtStart) begin
      sq_cd    <= SQRT_LAT - 1;
      sq_tgt   <= isqrt(oSqrtIn);
      iSqrtOut <= 16'($urandom);
    end else if (sq_cd > 1) begin
      sq_cd    <= sq_cd - 1;
      iSqrtOut <= 16'($urandom);
    end else if (sq_cd == 1) begin
      sq_cd    <= 0;
      iSqrtOut <= sq_tgt;
    end
  end

  // Transaction-level scheduler model: a job occupies JOB cycles from its grant decision
  always @(posedge iCLK) begin
    int g;
    int idx;
    if (iRST) begin
      m_pend = '0;
      for (int i = 0; i < N; i++) begin
        m_lat[i]  = '0;
        m_root[i] = '0;
      end
      m_rr        = N - 1;
      m_free      = cyc + 1;
      m_busy_from = cyc + 1;
      exp_q.delete();
      start_q.delete();
    end else begin
      if (cyc >= m_free && m_pend != '0) begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          idx = (m_rr + k) % N;
          if (g < 0 && m_pend[idx]) g = idx;
        end
        exp_q.push_back('{cyc + JOB, g, m_lat[g]});
        start_q.push_back('{cyc + 1, g, m_lat[g]});
        m_pend[g]   = 1'b0;
        m_rr        = g;
        m_busy_from = cyc + 1;
        m_free      = cyc + JOB;
        m_jobs++;
      end
      for (int i = 0; i < N; i++) begin
        if (iReq[i]) begin
          m_pend[i] = 1'b1;
          m_lat[i]  = iRadicand[i*IW +: IW];
        end
      end
    end
    cyc = cyc + 1;
  end

  // Cycle monitor: compare every output against the model, log observed results
  always @(negedge iCLK) begin
    logic [N-1:0]    ev;
    logic [N*OW-1:0] er;
    logic            es;
    logic            eb;
    logic [31:0]     srad;
    if (iRST) begin
      checks++;
      if (oValid !== '0 || oRoot !== '0 || oBusy !== 1'b0 || oSqrtIn !== '0 || oSqrtStart !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs valid=%0h root=%0h busy=%0b in=%0h start=%0b want all 0",
                 oValid, oRoot, oBusy, oSqrtIn, oSqrtStart);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_valid ch=%0d due cycle %0d now %0d", exp_q[0].ch, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      while (start_q.size() > 0 && start_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_start ch=%0d due cycle %0d now %0d", start_q[0].ch, start_q[0].cyc, cyc);
        void'(start_q.pop_front());
      end
      ev = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev[exp_q[0].ch]     = 1'b1;
        m_root[exp_q[0].ch] = isqrt(exp_q[0].rad);
        void'(exp_q.pop_front());
      end
      for (int i = 0; i < N; i++) er[i*OW +: OW] = m_root[i];
      checks++;
      if (oValid !== ev) begin
        errors++;
        $display("FAIL valid cycle %0d got %b want %b", cyc, oValid, ev);
      end
      checks++;
      if (oRoot !== er) begin
        errors++;
        $display("FAIL root cycle %0d got %h want %h", cyc, oRoot, er);
      end
      es   = 1'b0;
      srad = '0;
      if (start_q.size() > 0 && start_q[0].cyc == cyc) begin
        es   = 1'b1;
        srad = start_q[0].rad;
        void'(start_q.pop_front());
      end
      checks++;
      if (oSqrtStart !== es) begin
        errors++;
        $display("FAIL start cycle %0d got %b want %b", cyc, oSqrtStart, es);
      end
      if (es) begin
        checks++;
        if (oSqrtIn !== srad) begin
          errors++;
          $display("FAIL sqrt_in cycle %0d got %h want %h", cyc, oSqrtIn, srad);
        end
      end
      eb = (cyc >= m_busy_from) && (cyc < m_free);
      checks++;
      if (oBusy !== eb) begin
        errors++;
        $display("FAIL busy cycle %0d got %b want %b", cyc, oBusy, eb);
      end
      for (int i = 0; i < N; i++) begin
        if (oValid[i] === 1'b1) begin
          obs_ch.push_back(i);
          obs_root.push_back(int'(oRoot[i*OW +: OW]));
          obs_cyc.push_back(cyc);
        end
      end
      if (oSqrtStart === 1'b1) start_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    obs_ch.delete();
    obs_root.delete();
    obs_cyc.delete();
    start_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] r, input logic [N*IW-1:0] rad);
    iReq      = r;
    iRadicand = rad;
    @(posedge iCLK);
    #1;
    iReq = '0;
    for (int i = 0; i < N; i++) iRadicand[i*IW +: IW] = $urandom;
  endtask

  task automatic test_reset();
    iRST      = 1'b1;
    iReq      = '0;
    iRadicand = '0;
    idle(3);
    checks++;
    if (oValid !== '0 || oRoot !== '0 || oBusy !== 1'b0 || oSqrtIn !== '0 || oSqrtStart !== 1'b0) begin
      errors++;
      $display("FAIL test_reset held valid=%0h root=%0h busy=%0b want 0", oValid, oRoot, oBusy);
    end
    iRST = 1'b0;
    idle(3);
    checks++;
    if (oBusy !== 1'b0 || oValid !== '0) begin
      errors++;
      $display("FAIL test_reset idle busy=%0b valid=%0h want 0 0", oBusy, oValid);
    end
  endtask

  task automatic test_all_four();
    logic [N*IW-1:0] rad;
    int want[N];
    clear_log();
    rad[0*IW +: IW] = 32'd0;
    rad[1*IW +: IW] = 32'd1;
    rad[2*IW +: IW] = 32'hFFFF_FFFF;
    rad[3*IW +: IW] = 32'd3224990521;
    want = '{0, 1, 65535, 56789};
    pulse(4'b1111, rad);
    idle(N * JOB + 10);
    checks++;
    if (obs_ch.size() != N) begin
      errors++;
      $display("FAIL all_four count got %0d want %0d", obs_ch.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (obs_ch[i] != i || obs_root[i] != want[i]) begin
          errors++;
          $display("FAIL all_four result %0d got ch%0d root %0d want ch%0d root %0d",
                   i, obs_ch[i], obs_root[i], i, want[i]);
        end
        if (i > 0) begin
          checks++;
          if (obs_cyc[i] - obs_cyc[i-1] != JOB) begin
            errors++;
            $display("FAIL all_four spacing got %0d want %0d", obs_cyc[i] - obs_cyc[i-1], JOB);
          end
        end
      end
    end
  endtask

  task automatic test_single();
    int r;
    clear_log();
    r = cyc;
    pulse(4'b0001, one_rad(0, 32'd49283));
    idle(JOB + 10);
    checks++;
    if (obs_ch.size() != 1) begin
      errors++;
      $display("FAIL single count got %0d want 1", obs_ch.size());
    end else begin
      checks++;
      if (obs_ch[0] != 0 || obs_root[0] != 221) begin
        errors++;
        $display("FAIL single result got ch%0d root %0d want ch0 root 221", obs_ch[0], obs_root[0]);
      end
      checks++;
      if (start_cyc.size() != 1 || start_cyc[0] != r + 2 || obs_cyc[0] != r + 2 + SQRT_LAT + 2) begin
        errors++;
        $display("FAIL single latency start %0d valid %0d want %0d %0d",
                 (start_cyc.size() > 0) ? start_cyc[0] : -1, obs_cyc[0], r + 2, r + 2 + SQRT_LAT + 2);
      end
    end
  endtask

  task automatic test_overwrite();
    int n1;
    clear_log();
    pulse(4'b0001, one_rad(0, 32'd777777));
    pulse(4'b0010, one_rad(1, 32'd100));
    idle(1);
    pulse(4'b0010, one_rad(1, 32'd10000));
    idle(2 * JOB + 10);
    n1 = 0;
    foreach (obs_ch[i]) if (obs_ch[i] == 1) n1++;
    checks++;
    if (obs_ch.size() != 2 || n1 != 1) begin
      errors++;
      $display("FAIL overwrite counts got total %0d ch1 %0d want 2 1", obs_ch.size(), n1);
    end else begin
      checks++;
      if (obs_ch[1] != 1 || obs_root[1] != 100) begin
        errors++;
        $display("FAIL overwrite result got ch%0d root %0d want ch1 root 100", obs_ch[1], obs_root[1]);
      end
    end
  endtask

  task automatic test_fairness();
    int want[4];
    want = '{0, 2, 0, 0};
    clear_log();
    for (int k = 0; k < 80; k++) begin
      iReq = (k == 3) ? 4'b0101 : 4'b0001;
      for (int i = 0; i < N; i++) iRadicand[i*IW +: IW] = rand_rad();
      @(posedge iCLK);
      #1;
    end
    iReq = '0;
    idle(2 * JOB + 10);
    checks++;
    if (obs_ch.size() != 5) begin
      errors++;
      $display("FAIL fairness count got %0d want 5", obs_ch.size());
    end
    if (obs_ch.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_ch[i] != want[i]) begin
          errors++;
          $display("FAIL fairness order %0d got ch%0d want ch%0d", i, obs_ch[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    clear_log();
    pulse(4'b0001, one_rad(0, 32'd123456789));
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge iCLK);
      if (oSqrtStart === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_run start got none want pulse within 10 cycles");
    end
    repeat (5) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    #1;
    checks++;
    if (oValid !== '0 || oRoot !== '0 || oBusy !== 1'b0 || oSqrtIn !== '0 || oSqrtStart !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run immediate valid=%0h root=%0h busy=%0b in=%0h want 0",
               oValid, oRoot, oBusy, oSqrtIn);
    end
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    idle(JOB + 5);
    checks++;
    if (obs_ch.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_run stray results got %0d want 0", obs_ch.size());
    end
    pulse(4'b1000, one_rad(3, 32'd144));
    idle(JOB + 5);
    checks++;
    if (obs_ch.size() != 1 || obs_ch[0] != 3 || obs_root[0] != 12) begin
      errors++;
      $display("FAIL reset_mid_run after got %0d results first ch%0d root %0d want 1 ch3 root 12",
               obs_ch.size(), (obs_ch.size() > 0) ? obs_ch[0] : -1, (obs_root.size() > 0) ? obs_root[0] : -1);
    end
  endtask

  task automatic test_regrant();
    clear_log();
    pulse(4'b0010, one_rad(1, 32'd400));
    pulse(4'b0010, one_rad(1, 32'd81));
    idle(2 * JOB + 10);
    checks++;
    if (obs_ch.size() != 2) begin
      errors++;
      $display("FAIL regrant count got %0d want 2", obs_ch.size());
    end else begin
      checks++;
      if (obs_ch[0] != 1 || obs_root[0] != 20 || obs_ch[1] != 1 || obs_root[1] != 9) begin
        errors++;
        $display("FAIL regrant results got ch%0d/%0d ch%0d/%0d want ch1/20 ch1/9",
                 obs_ch[0], obs_root[0], obs_ch[1], obs_root[1]);
      end
      checks++;
      if (obs_cyc[1] - obs_cyc[0] != JOB) begin
        errors++;
        $display("FAIL regrant spacing got %0d want %0d", obs_cyc[1] - obs_cyc[0], JOB);
      end
    end
  endtask

  task automatic test_random();
    clear_log();
    m_jobs = 0;
    for (int k = 0; k < 1500; k++) begin
      iReq = 4'($urandom) & 4'($urandom) & 4'($urandom);
      for (int i = 0; i < N; i++) iRadicand[i*IW +: IW] = rand_rad();
      @(posedge iCLK);
      #1;
    end
    iReq = '0;
    idle(N * JOB + 20);
    checks++;
    if (exp_q.size() != 0 || start_q.size() != 0) begin
      errors++;
      $display("FAIL random drain got %0d/%0d outstanding want 0", exp_q.size(), start_q.size());
    end
    checks++;
    if (obs_ch.size() != m_jobs || m_jobs == 0) begin
      errors++;
      $display("FAIL random job_count got %0d want %0d", obs_ch.size(), m_jobs);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_overwrite();
    test_fairness();
    test_reset_mid_run();
    test_regrant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
